// File: rtl/and_gate_pkg.sv
// Shared constants and types for the registered AND block.
package and_gate_pkg;

  // Default lane count when the parent does not override WIDTH.
  localparam int AND_DEF_WIDTH  = 1;

  // Deepest pipeline the block is built and checked for.
  localparam int AND_MAX_STAGES = 4;

  // One lane of the default-width datapath.
  typedef logic [AND_DEF_WIDTH-1:0] and_lane_t;

endpackage : and_gate_pkg

// File: rtl/and_gate_stage.sv
// One pipeline slice of the AND datapath: a data register and its valid flag.
//
// Handshake: valid_i qualifies data_i in the cycle it is high. There is no
// ready signal because downstream never stalls. The slice loads data only
// when valid_i is 1, and valid_o copies valid_i every cycle. As a result, a
// bubble leaves the previous data in place but drops valid_o.
module and_gate_stage
  import and_gate_pkg::*;
#(
  parameter int WIDTH = AND_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic             valid_d;

  // Next state: load data on a valid beat, otherwise hold; valid always follows.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_i;
    if (valid_i) begin
      data_d = data_i;
    end
  end

  // Slice registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule : and_gate_stage

// File: rtl/and_gate_sync.sv
// Registered, parameterisable bitwise AND with a fixed-depth valid pipeline.
//
// out = a & b, per lane, PIPE_STAGES register stages after capture. A sample
// captured at edge N appears at edge N+PIPE_STAGES-1. all_ones is registered
// alongside the last stage from that stage's incoming data. This keeps it
// consistent with out in every cycle, including when out holds during a bubble.
// Every output comes straight from a flop.
module and_gate_sync
  import and_gate_pkg::*;
#(
  parameter int WIDTH       = AND_DEF_WIDTH,
  parameter int PIPE_STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             all_ones
);

  // Elaboration-time parameter guards.
  if (WIDTH < 1) begin : g_bad_width
    $error("and_gate_sync: WIDTH must be at least 1");
  end
  if ((PIPE_STAGES < 1) || (PIPE_STAGES > AND_MAX_STAGES)) begin : g_bad_stages
    $error("and_gate_sync: PIPE_STAGES must be within 1..%0d", AND_MAX_STAGES);
  end

  // chain_*[k] is the input of stage k; chain_*[PIPE_STAGES] is the output.
  logic [WIDTH-1:0] chain_data  [PIPE_STAGES+1];
  logic             chain_valid [PIPE_STAGES+1];

  // The AND array feeds stage 0 directly.
  assign chain_data[0]  = a & b;
  assign chain_valid[0] = in_valid;

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    and_gate_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_i  (chain_data[k]),
      .valid_i (chain_valid[k]),
      .data_o  (chain_data[k+1]),
      .valid_o (chain_valid[k+1])
    );
  end

  logic all_ones_q;
  logic all_ones_d;

  // all_ones uses the same load rule as the final stage, so it tracks out exactly.
  always_comb begin
    all_ones_d = all_ones_q;
    if (chain_valid[PIPE_STAGES-1]) begin
      all_ones_d = &chain_data[PIPE_STAGES-1];
    end
  end

  // all_ones register, cleared with the rest of the pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      all_ones_q <= 1'b0;
    end else begin
      all_ones_q <= all_ones_d;
    end
  end

  assign out       = chain_data[PIPE_STAGES];
  assign out_valid = chain_valid[PIPE_STAGES];
  assign all_ones  = all_ones_q;

endmodule : and_gate_sync

// File: tb/tb_and_gate_sync.sv
// Bench for and_gate_sync: a default instance (WIDTH=1, PIPE_STAGES=1) and a
// WIDTH=8, PIPE_STAGES=3 instance. Drivers push {all_ones, out} expectations
// with the cycle they are due. Monitors check on the falling edge.
module tb_and_gate_sync;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst8_n;

  logic       a1, b1, iv1;
  logic       out1, ov1, ao1;
  logic [7:0] a8, b8, out8;
  logic       iv8, ov8, ao8;

  and_gate_sync u_dut1 (
    .clk       (clk),
    .rst_n     (rst1_n),
    .a         (a1),
    .b         (b1),
    .in_valid  (iv1),
    .out       (out1),
    .out_valid (ov1),
    .all_ones  (ao1)
  );

  and_gate_sync #(
    .WIDTH       (8),
    .PIPE_STAGES (3)
  ) u_dut8 (
    .clk       (clk),
    .rst_n     (rst8_n),
    .a         (a8),
    .b         (b8),
    .in_valid  (iv8),
    .out       (out8),
    .out_valid (ov8),
    .all_ones  (ao8)
  );

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q1[$];
  logic [8:0] exp_q8[$];
  int         due_q1[$];
  int         due_q8[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic       rst1_seen = 1'b0;
  logic       rst8_seen = 1'b0;
  logic [8:0] last1 = '0;
  logic [8:0] last8 = '0;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rst1_seen <= !rst1_n;
    rst8_seen <= !rst8_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [8:0] act;
    logic [8:0] e;
    logic       exp_v;
    act   = {ao1, 7'd0, out1};
    exp_v = (due_q1.size() != 0) && (due_q1[0] == cyc);
    if (rst1_seen) begin
      check("d1_reset", {22'd0, ov1, act}, 32'd0);
      last1 = '0;
    end else begin
      check("d1_out_valid", {31'd0, ov1}, {31'd0, exp_v});
      if (exp_v) begin
        e = exp_q1.pop_front();
        void'(due_q1.pop_front());
        check("d1_data", {23'd0, act}, {23'd0, e});
        last1 = e;
      end else begin
        check("d1_hold", {23'd0, act}, {23'd0, last1});
      end
    end
  end

  always @(negedge clk) begin
    logic [8:0] act;
    logic [8:0] e;
    logic       exp_v;
    act   = {ao8, out8};
    exp_v = (due_q8.size() != 0) && (due_q8[0] == cyc);
    if (rst8_seen) begin
      check("d8_reset", {22'd0, ov8, act}, 32'd0);
      last8 = '0;
    end else begin
      check("d8_out_valid", {31'd0, ov8}, {31'd0, exp_v});
      if (exp_v) begin
        e = exp_q8.pop_front();
        void'(due_q8.pop_front());
        check("d8_data", {23'd0, act}, {23'd0, e});
        last8 = e;
      end else begin
        check("d8_hold", {23'd0, act}, {23'd0, last8});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive one beat on the 1-bit instance; e is the hand-computed a&b.
  task automatic drv1(input logic a, input logic b, input logic v, input logic e);
    a1  = a;
    b1  = b;
    iv1 = v;
    if (v && rst1_n) begin
      exp_q1.push_back({e, 7'd0, e});
      due_q1.push_back(cyc + 1);
    end
    step();
  endtask

  // Drive one beat on the 8-bit instance; e/eao are hand-computed.
  task automatic drv8(input logic [7:0] a, input logic [7:0] b, input logic v,
                      input logic [7:0] e, input logic eao);
    a8  = a;
    b8  = b;
    iv8 = v;
    if (v && rst8_n) begin
      exp_q8.push_back({eao, e});
      due_q8.push_back(cyc + 3);
    end
    step();
  endtask

  // Hold reset low for n edges; anything in flight is discarded at the first one.
  task automatic reset1(input int n);
    rst1_n = 1'b0;
    step();
    exp_q1.delete();
    due_q1.delete();
    repeat (n - 1) step();
    rst1_n = 1'b1;
  endtask

  task automatic reset8(input int n);
    rst8_n = 1'b0;
    step();
    exp_q8.delete();
    due_q8.delete();
    repeat (n - 1) step();
    rst8_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  // {a, b, expected out} for the truth table.
  logic [2:0] vec1 [4] = '{3'b000, 3'b010, 3'b100, 3'b111};

  initial begin
    logic [2:0] v;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] re;

    rst1_n = 1'b0;
    rst8_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; iv1 = 1'b0;
    a8 = '0;   b8 = '0;   iv8 = 1'b0;
    step();
    step();
    rst1_n = 1'b1;
    rst8_n = 1'b1;

    // Truth table, each pair held for 100 time units.
    for (int i = 0; i < 4; i++) begin
      v = vec1[i];
      repeat (10) drv1(v[2], v[1], 1'b1, v[0]);
    end
    drv1(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset for two edges with a=b=1, then release: out=1 one edge later.
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
    reset1(2);
    drv1(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) drv1(1'b0, 1'b0, 1'b0, 1'b0);

    // Bubble: 1&1, two idle cycles, then 0&1.
    drv1(1'b1, 1'b1, 1'b1, 1'b1);
    drv1(1'b0, 1'b0, 1'b0, 1'b0);
    drv1(1'b0, 1'b0, 1'b0, 1'b0);
    drv1(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) drv1(1'b0, 1'b0, 1'b0, 1'b0);

    // 8-bit, 3-stage directed vectors.
    drv8(8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0);
    drv8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    drv8(8'hFE, 8'hFF, 1'b1, 8'hFE, 1'b0);
    drv8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    drv8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    repeat (5) drv8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // Mid-flight reset one cycle after a valid sample: it must never appear.
    drv8(8'hAA, 8'h0F, 1'b1, 8'h0A, 1'b0);
    a8 = '0; b8 = '0; iv8 = 1'b0;
    reset8(2);
    repeat (6) drv8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // Streaming: 16 back-to-back random vectors.
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      re = ra & rb;
      drv8(ra, rb, 1'b1, re, re == 8'hFF);
    end
    repeat (6) drv8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    // Every expected result must have been presented.
    check("d1_drain", exp_q1.size(), 32'd0);
    check("d8_drain", exp_q8.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_and_gate_sync
